branch_predict_ctrl: RTL and testbench

- Branch prediction and redirect controller for the rv32i pipeline.
- Holds a bimodal branch history table (BHT) of 2-bit saturating counters and supplies a taken/not-taken prediction to IF for conditional branches.
- Compares the EX-stage branch resolution (branch unit PcSel/BrPC) against the carried prediction, updates the BHT, and sequences the redirect and flush of IF/ID and ID/EX on mispredict or jump.

---
 rtl/branch_predict_ctrl.sv | 90 +++++++++
 tb/tb_branch_predict_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: bimodal branch predictor and redirect/flush sequencer for the rv32i pipeline.
//   Optional statistics counters are enabled by defining the macro BP_STATS_EN.
//   Ports:
//     clk, reset                - clock, synchronous active-high reset
//     if_pc / pred_taken        - IF-stage PC and its combinational taken prediction
//     ex_valid, ex_branch, ex_jump, ex_pc, ex_pred_taken, ex_taken, ex_target, ex_pc_four
//                               - EX-stage branch resolution inputs
//     redirect_valid, redirect_pc, flush_if_id, flush_id_ex
//                               - registered one-cycle redirect and flush pulse
//     stat_branches, stat_mispredicts - resolved/mispredicted branch counts (0 without BP_STATS_EN)
module branch_predict_ctrl #(
   parameter int PC_W  = 9,
   parameter int IDX_W = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W-1:0] if_pc,
   output logic            pred_taken,
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic            ex_jump,
   input  logic [PC_W-1:0] ex_pc,
   input  logic            ex_pred_taken,
   input  logic            ex_taken,
   input  logic [31:0]     ex_target,
   input  logic [31:0]     ex_pc_four,
   output logic            redirect_valid,
   output logic [31:0]     redirect_pc,
   output logic            flush_if_id,
   output logic            flush_id_ex,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
);
   typedef enum logic {RUN, SHADOW} state_t;

   state_t           state;
   logic [1:0]       bht [2**IDX_W];
   logic [IDX_W-1:0] ridx, widx;
   logic             res, is_br, br_mis, mis;
   logic             unused;

   assign ridx   = if_pc[IDX_W+1:2];
   assign widx   = ex_pc[IDX_W+1:2];
   assign pred_taken = bht[ridx][1];
   // In SHADOW the EX instruction is wrong-path and must have no effect.
   assign res    = ex_valid && state == RUN;
   // A branch+jump combination behaves purely as a jump.
   assign is_br  = res && ex_branch && !ex_jump;
   assign br_mis = is_br && ex_taken != ex_pred_taken;
   // IF always treats jumps as not-taken, so every jump redirects.
   assign mis    = res && ((ex_branch && ex_taken != ex_pred_taken) || ex_jump);
   assign unused = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0], ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2**IDX_W; i++) bht[i] <= 2'b01;
         state          <= RUN;
         redirect_valid <= 1'b0;
         flush_if_id    <= 1'b0;
         flush_id_ex    <= 1'b0;
         redirect_pc    <= 32'b0;
      end else begin
         if (is_br)
            bht[widx] <= ex_taken ? (bht[widx] == 2'b11 ? 2'b11 : bht[widx] + 2'b01)
                                  : (bht[widx] == 2'b00 ? 2'b00 : bht[widx] - 2'b01);
         state          <= mis ? SHADOW : RUN;
         redirect_valid <= mis;
         flush_if_id    <= mis;
         flush_id_ex    <= mis;
         if (mis) redirect_pc <= (ex_taken || ex_jump) ? ex_target : ex_pc_four;
      end
   end

`ifdef BP_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_branches    <= 32'b0;
         stat_mispredicts <= 32'b0;
      end else begin
         if (is_br && stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
         if (br_mis && stat_mispredicts != 32'hFFFF_FFFF) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`else
   logic unused_br_mis;
   assign unused_br_mis    = br_mis;
   assign stat_branches    = 32'b0;
   assign stat_mispredicts = 32'b0;
`endif
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: scoreboard bench for branch_predict_ctrl against a counter-array reference model.
module tb_branch_predict_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [8:0]  if_pc, ex_pc;
   logic        pred_taken, ex_valid, ex_branch, ex_jump, ex_pred_taken, ex_taken;
   logic [31:0] ex_target, ex_pc_four, redirect_pc, stat_branches, stat_mispredicts;
   logic        redirect_valid, flush_if_id, flush_id_ex;

   branch_predict_ctrl #(.PC_W(9), .IDX_W(4)) dut (
      .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_pc(ex_pc),
      .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken), .ex_target(ex_target),
      .ex_pc_four(ex_pc_four), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   always #5 clk = ~clk;

   int          total = 0, bad = 0;
   int          m_cnt [16];
   bit          m_shadow = 0, mon_en = 0;
   logic [31:0] exp_rpc = 0, m_br = 0, m_mis = 0;
   logic [31:0] sb_q [$];

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", n, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_cnt[i] = 1;
      m_shadow = 0;
      exp_rpc  = 0;
      m_br     = 0;
      m_mis    = 0;
   endtask

   // One cycle: drive at negedge, check prediction, advance model at posedge.
   task automatic step(input bit r, input bit v, input bit br, input bit j, input bit tk,
                       input bit pt, input logic [8:0] ipc, input logic [8:0] epc,
                       input logic [31:0] tgt);
      bit res, mis, isbr;
      int k;
      reset = r; ex_valid = v; ex_branch = br; ex_jump = j; ex_taken = tk;
      ex_pred_taken = pt; if_pc = ipc; ex_pc = epc; ex_target = tgt;
      ex_pc_four = {23'b0, epc} + 32'd4;
      #1;
      if (mon_en) check("pred_taken", {31'b0, pred_taken}, {31'b0, m_cnt[ipc[5:2]] >= 2});
      res  = v && !m_shadow;
      isbr = res && br && !j;
      mis  = res && ((br && tk != pt) || j);
      k    = epc[5:2];
      @(posedge clk);
      if (r) model_reset();
      else begin
         if (isbr) begin
            m_cnt[k] = tk ? (m_cnt[k] < 3 ? m_cnt[k] + 1 : 3) : (m_cnt[k] > 0 ? m_cnt[k] - 1 : 0);
            if (m_br != 32'hFFFF_FFFF) m_br++;
            if (tk != pt && m_mis != 32'hFFFF_FFFF) m_mis++;
         end
         m_shadow = mis;
         if (mis) begin
            exp_rpc = (tk || j) ? tgt : {23'b0, epc} + 32'd4;
            sb_q.push_back(exp_rpc);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic [8:0] ipc);
      step(0, 0, 0, 0, 0, 0, ipc, 9'h0, 32'h0);
   endtask

   // Monitor: pops the scoreboard whenever a redirect is due and checks all outputs.
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         check("flush_if_id", {31'b0, flush_if_id}, {31'b0, redirect_valid});
         check("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, redirect_valid});
         if (sb_q.size() != 0) begin
            logic [31:0] e;
            e = sb_q.pop_front();
            check("redirect_valid", {31'b0, redirect_valid}, 32'd1);
            check("redirect_pc", redirect_pc, e);
         end else begin
            check("redirect_valid", {31'b0, redirect_valid}, 32'd0);
            check("redirect_pc_hold", redirect_pc, exp_rpc);
         end
`ifdef BP_STATS_EN
         check("stat_branches", stat_branches, m_br);
         check("stat_mispredicts", stat_mispredicts, m_mis);
`else
         check("stat_branches", stat_branches, 32'd0);
         check("stat_mispredicts", stat_mispredicts, 32'd0);
`endif
      end
   end

   initial begin
      model_reset();
      reset = 1; ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_taken = 0; ex_pred_taken = 0;
      if_pc = 0; ex_pc = 0; ex_target = 0; ex_pc_four = 0;
      @(negedge clk);
      step(1, 0, 0, 0, 0, 0, 9'h010, 9'h0, 32'h0);
      mon_en = 1;
      step(1, 0, 0, 0, 0, 0, 9'h010, 9'h0, 32'h0);
      check("reset_pred", {31'b0, pred_taken}, 32'd0);
      // Saturating increment at 0x010, correctly predicted (no redirect).
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 1, 1, 9'h010, 9'h010, 32'h80);
      idle(9'h010);
      check("sat_pred", {31'b0, pred_taken}, 32'd1);
      // Mispredict taken, then not-taken redirect to pc+4.
      step(0, 1, 1, 0, 1, 0, 9'h000, 9'h020, 32'h40);
      idle(9'h000);
      step(0, 1, 1, 0, 0, 1, 9'h000, 9'h020, 32'h99);
      idle(9'h000);
      // Mispredict followed by a wrong-path mispredict in SHADOW.
      step(0, 1, 1, 0, 1, 0, 9'h030, 9'h020, 32'h60);
      step(0, 1, 1, 0, 1, 0, 9'h030, 9'h030, 32'h70);
      idle(9'h030);
      check("shadow_pred", {31'b0, pred_taken}, 32'd0);
      // Jump redirect without BHT effect.
      step(0, 1, 0, 1, 0, 0, 9'h000, 9'h000, 32'h100);
      idle(9'h000);
      step(0, 1, 1, 1, 1, 1, 9'h000, 9'h000, 32'h104);
      idle(9'h000);
      // Reset coincident with a mispredict drops it and restores all entries.
      step(1, 1, 1, 0, 1, 0, 9'h010, 9'h010, 32'h200);
      for (int i = 0; i < 16; i++) idle(9'(i * 4));
      // Same-cycle read/write at aliased index: old value seen, new one next cycle.
      step(0, 1, 1, 0, 1, 1, 9'h044, 9'h004, 32'h0);
      step(0, 1, 1, 0, 0, 0, 9'h044, 9'h004, 32'h0);
      idle(9'h044);
      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 5) == 0, 1'($urandom), 1'($urandom),
              {7'($urandom), 2'b00}, {7'($urandom), 2'b00}, $urandom);
      end
      idle(9'h0);
      idle(9'h0);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
